// File: rtl/psram_xfer_seq_if.sv
// Request-side and transceiver-side signal bundle for psram_xfer_seq.
// The sequencer connects as slave; the requester/transceiver side is master.
interface psram_xfer_seq_if #(
  parameter int RAM_AW = 10
);
  logic              req_vld;
  logic              req_rdy;
  logic              req_dir;
  logic [23:0]       req_paddr;
  logic [23:0]       req_len;
  logic [RAM_AW-1:0] req_ram_saddr;
  logic [3:0]        sck_div;
  logic              quad_en;
  logic              start;
  logic              done;
  logic [31:0]       cfg0;
  logic [31:0]       cfg1;
  logic [31:0]       cfg2;
  logic [31:0]       cfg3;
  logic              busy;
  logic              req_done;
  logic              req_err;

  modport slave (
    input  req_vld, req_dir, req_paddr, req_len, req_ram_saddr, sck_div, quad_en, done,
    output req_rdy, start, cfg0, cfg1, cfg2, cfg3, busy, req_done, req_err
  );

  modport master (
    output req_vld, req_dir, req_paddr, req_len, req_ram_saddr, sck_div, quad_en, done,
    input  req_rdy, start, cfg0, cfg1, cfg2, cfg3, busy, req_done, req_err
  );
endinterface

// File: rtl/psram_xfer_seq.sv
// Splits one PSRAM request into page-bounded, length-capped bursts and drives
// psram_trx through cfg0..cfg3/start/done, with a per-burst timeout.
module psram_xfer_seq #(
  parameter int          RAM_AW     = 10,
  parameter int          PAGE_BYTES = 1024,
  parameter int          MAX_BURST  = 256,
  parameter logic [7:0]  WR_CMD     = 8'h38,
  parameter logic [7:0]  RD_CMD     = 8'hEB,
  parameter int          RD_WAIT    = 6,
  parameter int          TIMEOUT    = 65535
) (
  input logic              hclk,
  input logic              hrstn,
  psram_xfer_seq_if.slave  bus
);

  localparam int          TW          = $clog2(TIMEOUT + 1);
  localparam logic [23:0] PAGE_MASK   = 24'(PAGE_BYTES - 1);
  localparam logic [24:0] PAGE_SIZE   = 25'(PAGE_BYTES);
  localparam logic [14:0] MAX_LEN     = 15'(MAX_BURST);
  localparam logic [3:0]  RD_WAIT_CYC = 4'(RD_WAIT);

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT, FIN} state_t;
  state_t state, state_nxt;

  logic [23:0]       cur_paddr, remain;
  logic [RAM_AW-1:0] cur_ram;
  logic              dir_q, err_q;
  logic [14:0]       burst_q;
  logic [TW-1:0]     tmo_cnt;
  logic              req_rdy_q, start_q, busy_q, req_done_q, req_err_q;
  logic [31:0]       cfg0_q, cfg1_q, cfg2_q;

  logic              accept, misaligned, tmo_hit, last_burst;
  logic [24:0]       page_room;
  logic [14:0]       burst_lim, burst_calc;
  logic [31:0]       cfg0_d, cfg1_d, cfg2_d;
  logic [1:0]        io_width;

  assign accept     = bus.req_vld && req_rdy_q && (state == IDLE);
  assign misaligned = (|bus.req_paddr[1:0]) || (|bus.req_len[1:0]);
  assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT - 1));
  assign last_burst = (remain == {9'd0, burst_q});

  // Burst is the smallest of what is left, the length cap and the room to the page end.
  always_comb begin
    page_room  = PAGE_SIZE - {1'b0, cur_paddr & PAGE_MASK};
    burst_lim  = (page_room < {10'd0, MAX_LEN}) ? page_room[14:0] : MAX_LEN;
    burst_calc = (remain < {9'd0, burst_lim}) ? remain[14:0] : burst_lim;
    io_width   = bus.quad_en ? 2'd2 : 2'd0;
    cfg0_d     = {2'b00, 1'b0, io_width, (dir_q ? 4'd0 : RD_WAIT_CYC), io_width,
                  dir_q, ~bus.quad_en, bus.sck_div, burst_calc};
    cfg1_d     = {(dir_q ? WR_CMD : RD_CMD), cur_paddr};
    cfg2_d     = '0;
    cfg2_d[14:0]          = {2'b00, burst_calc[14:2]};
    cfg2_d[16 +: RAM_AW]  = cur_ram;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned)             state_nxt = FIN;
          else if (bus.req_len == '0) state_nxt = FIN;
          else                        state_nxt = CALC;
        end
      end
      CALC:  state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (bus.done)     state_nxt = last_burst ? FIN : CALC;
        else if (tmo_hit) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) state <= IDLE;
    else        state <= state_nxt;
  end

  // Handshake outputs follow the next state; req_done/req_err land the cycle after FIN.
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      cur_paddr  <= '0;
      remain     <= '0;
      cur_ram    <= '0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
      burst_q    <= '0;
      tmo_cnt    <= '0;
      req_rdy_q  <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      req_done_q <= 1'b0;
      req_err_q  <= 1'b0;
      cfg0_q     <= '0;
      cfg1_q     <= '0;
      cfg2_q     <= '0;
    end else begin
      req_rdy_q  <= (state_nxt == IDLE);
      start_q    <= (state_nxt == ISSUE);
      busy_q     <= (state_nxt == CALC) || (state_nxt == ISSUE) || (state_nxt == WAIT);
      req_done_q <= (state == FIN);
      req_err_q  <= (state == FIN) && err_q;

      case (state)
        IDLE: begin
          if (accept) begin
            cur_paddr <= bus.req_paddr;
            remain    <= bus.req_len;
            cur_ram   <= bus.req_ram_saddr;
            dir_q     <= bus.req_dir;
            err_q     <= misaligned;
          end
        end
        CALC: begin
          burst_q <= burst_calc;
          cfg0_q  <= cfg0_d;
          cfg1_q  <= cfg1_d;
          cfg2_q  <= cfg2_d;
        end
        ISSUE: tmo_cnt <= '0;
        WAIT: begin
          if (bus.done) begin
            cur_paddr <= cur_paddr + {9'd0, burst_q};
            remain    <= remain - {9'd0, burst_q};
            cur_ram   <= cur_ram + RAM_AW'(burst_q[14:2]);
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: ;
      endcase

      if (state_nxt == FIN) begin
        cfg0_q <= '0;
        cfg1_q <= '0;
        cfg2_q <= '0;
      end
    end
  end

  assign bus.req_rdy  = req_rdy_q;
  assign bus.start    = start_q;
  assign bus.busy     = busy_q;
  assign bus.req_done = req_done_q;
  assign bus.req_err  = req_err_q;
  assign bus.cfg0     = cfg0_q;
  assign bus.cfg1     = cfg1_q;
  assign bus.cfg2     = cfg2_q;
  assign bus.cfg3     = '0;

endmodule

// File: tb/tb_psram_xfer_seq.sv
// Self-checking bench for psram_xfer_seq: vector table, hand-written corner
// sequences and random requests against a burst-list reference model.
module tb_psram_xfer_seq;

  localparam int RAM_AW     = 10;
  localparam int PAGE_BYTES = 1024;
  localparam int MAX_BURST  = 256;
  localparam int RD_WAIT    = 6;
  localparam int TIMEOUT    = 16;

  logic hclk;
  logic hrstn;
  int   n_checks = 0;
  int   n_errors = 0;

  psram_xfer_seq_if #(.RAM_AW(RAM_AW)) bus ();

  psram_xfer_seq #(
    .RAM_AW(RAM_AW), .PAGE_BYTES(PAGE_BYTES), .MAX_BURST(MAX_BURST),
    .WR_CMD(8'h38), .RD_CMD(8'hEB), .RD_WAIT(RD_WAIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .hclk(hclk),
    .hrstn(hrstn),
    .bus(bus.slave)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    int addr;
    int bytes;
    int ram;
  } burst_t;

  typedef struct {
    logic        dir;
    logic        quad;
    logic [3:0]  sck;
    logic [23:0] paddr;
    logic [23:0] len;
    logic [9:0]  saddr;
    int          dly;
    int          exp_bursts;
    logic        exp_err;
    logic [31:0] exp_cfg1;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] expCfg0(int b, logic dir, logic quad, logic [3:0] sck);
    int w;
    w = b + (int'(sck) << 15) + ((quad ? 0 : 1) << 19) + (int'(dir) << 20)
          + ((quad ? 2 : 0) << 21) + ((dir ? 0 : RD_WAIT) << 23) + ((quad ? 2 : 0) << 27);
    return 32'(w);
  endfunction

  function automatic logic [31:0] expCfg1(int addr, logic dir);
    return ((dir ? 32'h38 : 32'hEB) << 24) | 32'(addr);
  endfunction

  function automatic logic [31:0] expCfg2(int b, int ram);
    return 32'(b / 4 + ram * 65536);
  endfunction

  // One request end to end; done is returned dly cycles after each start (0 = random, >TIMEOUT = never).
  task automatic applyStimulus(input logic dir, input logic quad, input logic [3:0] sck,
                               input logic [23:0] paddr, input logic [23:0] len,
                               input logic [RAM_AW-1:0] saddr, input int dly,
                               output int n_starts, output logic got_err, output logic [31:0] first_cfg1);
    burst_t exp_q[$];
    burst_t bb;
    int a, r, m, room, b, n_exp, cyc, done_cyc, exp_start_cyc, exp_fin_cyc, d, waited;
    bit misal, timed_out, exp_err, finished;

    misal = (paddr[1:0] != 2'b00) || (len[1:0] != 2'b00);
    a = int'(paddr); r = int'(len); m = int'(saddr);
    if (!misal) begin
      while (r > 0) begin
        room = PAGE_BYTES - (a % PAGE_BYTES);
        b = r;
        if (b > MAX_BURST) b = MAX_BURST;
        if (b > room) b = room;
        bb.addr = a; bb.bytes = b; bb.ram = m;
        exp_q.push_back(bb);
        a = (a + b) % (1 << 24);
        r = r - b;
        m = (m + b / 4) % (1 << RAM_AW);
      end
    end
    timed_out = (dly > TIMEOUT) && (exp_q.size() > 0);
    n_exp     = timed_out ? 1 : exp_q.size();
    exp_err   = misal || timed_out;

    waited = 0;
    do begin
      @(negedge hclk);
      waited++;
    end while (!bus.req_rdy && waited < 40);
    checkOutput("req_rdy_before_request", bus.req_rdy, 1'b1);

    bus.req_dir = dir; bus.quad_en = quad; bus.sck_div = sck;
    bus.req_paddr = paddr; bus.req_len = len; bus.req_ram_saddr = saddr;
    bus.req_vld = 1'b1;
    bus.done = 1'b0;

    cyc = 0; done_cyc = -1; exp_start_cyc = 2; exp_fin_cyc = (n_exp == 0) ? 2 : -1;
    n_starts = 0; got_err = 1'b0; first_cfg1 = '0; finished = 1'b0;
    while (!finished && cyc < 1000) begin
      @(negedge hclk);
      cyc++;
      bus.req_vld = 1'b0;
      bus.done = (cyc == done_cyc);
      if (bus.start) begin
        if (n_starts >= n_exp) begin
          checkOutput("unexpected_start", 1'b1, 1'b0);
        end else begin
          bb = exp_q[n_starts];
          checkOutput("start_cycle", cyc, exp_start_cyc);
          checkOutput("cfg0", bus.cfg0, expCfg0(bb.bytes, dir, quad, sck));
          checkOutput("cfg1", bus.cfg1, expCfg1(bb.addr, dir));
          checkOutput("cfg2", bus.cfg2, expCfg2(bb.bytes, bb.ram));
          checkOutput("cfg3", bus.cfg3, 32'h0);
          checkOutput("busy_in_burst", bus.busy, 1'b1);
          checkOutput("req_rdy_in_burst", bus.req_rdy, 1'b0);
          if (n_starts == 0) first_cfg1 = bus.cfg1;
          if (timed_out) begin
            exp_fin_cyc = cyc + TIMEOUT + 2;
          end else begin
            d = (dly == 0) ? int'($urandom_range(1, TIMEOUT)) : dly;
            done_cyc = cyc + d;
            if (n_starts == n_exp - 1) exp_fin_cyc = done_cyc + 2;
            else                       exp_start_cyc = done_cyc + 2;
          end
        end
        n_starts++;
      end
      if (bus.req_done) begin
        checkOutput("req_done_cycle", cyc, exp_fin_cyc);
        checkOutput("req_err", bus.req_err, exp_err);
        checkOutput("busy_at_req_done", bus.busy, 1'b0);
        got_err = bus.req_err;
        finished = 1'b1;
      end
    end
    if (!finished) checkOutput("req_done_timeout", 1'b0, 1'b1);
    checkOutput("start_count", n_starts, n_exp);
    bus.done = 1'b0;
  endtask

  vec_t        vecs[9];
  int          n_st;
  logic        g_err;
  logic [31:0] g_cfg1;
  int          waited;
  logic [23:0] pa, ln;
  int          sel;

  initial begin
    bus.req_vld = 1'b0; bus.req_dir = 1'b0; bus.req_paddr = '0; bus.req_len = '0;
    bus.req_ram_saddr = '0; bus.sck_div = '0; bus.quad_en = 1'b0; bus.done = 1'b0;
    hrstn = 1'b1;
    #2 hrstn = 1'b0;

    //            dir   quad  sck   paddr         len         saddr    dly bursts err   first cfg1
    vecs[0] = '{1'b1, 1'b1, 4'd3, 24'h0003C0, 24'h000100, 10'h010, 3,  2, 1'b0, 32'h380003C0};
    vecs[1] = '{1'b0, 1'b0, 4'd1, 24'h000000, 24'h000300, 10'h000, 5,  3, 1'b0, 32'hEB000000};
    vecs[2] = '{1'b1, 1'b1, 4'd0, 24'h000040, 24'h000000, 10'h000, 2,  0, 1'b0, 32'h00000000};
    vecs[3] = '{1'b0, 1'b1, 4'd0, 24'h000002, 24'h000010, 10'h000, 2,  0, 1'b1, 32'h00000000};
    vecs[4] = '{1'b1, 1'b0, 4'd2, 24'h000100, 24'h000102, 10'h000, 2,  0, 1'b1, 32'h00000000};
    vecs[5] = '{1'b0, 1'b1, 4'd4, 24'h000800, 24'h000200, 10'h005, 17, 1, 1'b1, 32'hEB000800};
    vecs[6] = '{1'b1, 1'b1, 4'd5, 24'h001000, 24'h000008, 10'h3FF, 16, 1, 1'b0, 32'h38001000};
    vecs[7] = '{1'b0, 1'b0, 4'd6, 24'hFFFFF0, 24'h000020, 10'h100, 4,  2, 1'b0, 32'hEBFFFFF0};
    vecs[8] = '{1'b1, 1'b0, 4'd7, 24'h0003FC, 24'h000400, 10'h3FE, 1,  5, 1'b0, 32'h380003FC};

    repeat (2) @(negedge hclk);
    checkOutput("reset_req_rdy", bus.req_rdy, 1'b0);
    checkOutput("reset_start", bus.start, 1'b0);
    checkOutput("reset_busy", bus.busy, 1'b0);
    checkOutput("reset_req_done", bus.req_done, 1'b0);
    checkOutput("reset_cfg0", bus.cfg0, 32'h0);
    checkOutput("reset_cfg1", bus.cfg1, 32'h0);
    hrstn = 1'b1;
    @(negedge hclk);
    checkOutput("req_rdy_after_release", bus.req_rdy, 1'b1);

    bus.done = 1'b1;
    @(negedge hclk);
    bus.done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checkOutput("idle_done_busy", bus.busy, 1'b0);
      checkOutput("idle_done_start", bus.start, 1'b0);
      checkOutput("idle_done_req_done", bus.req_done, 1'b0);
      checkOutput("idle_done_req_rdy", bus.req_rdy, 1'b1);
      @(negedge hclk);
    end

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].dir, vecs[i].quad, vecs[i].sck, vecs[i].paddr, vecs[i].len,
                    vecs[i].saddr, vecs[i].dly, n_st, g_err, g_cfg1);
      checkOutput("vec_bursts", n_st, vecs[i].exp_bursts);
      checkOutput("vec_err", g_err, vecs[i].exp_err);
      checkOutput("vec_first_cfg1", g_cfg1, vecs[i].exp_cfg1);
    end

    // req_vld held high: the second copy is taken only once the first has finished.
    @(negedge hclk);
    checkOutput("hold_req_rdy_initial", bus.req_rdy, 1'b1);
    bus.req_dir = 1'b1; bus.quad_en = 1'b1; bus.sck_div = 4'd1;
    bus.req_paddr = 24'h000040; bus.req_len = 24'h000004; bus.req_ram_saddr = '0;
    bus.req_vld = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge hclk);
      checkOutput("hold_start", bus.start, (c == 2) || (c == 7));
      checkOutput("hold_req_done", bus.req_done, (c == 5) || (c == 10));
      checkOutput("hold_req_rdy", bus.req_rdy, (c == 5) || (c >= 10));
      bus.done = (c == 3) || (c == 8);
      if (c == 6) bus.req_vld = 1'b0;
    end
    bus.done = 1'b0;

    // Reset while a burst is outstanding.
    bus.req_dir = 1'b1; bus.quad_en = 1'b1; bus.req_paddr = 24'h0; bus.req_len = 24'h100;
    bus.req_vld = 1'b1;
    @(negedge hclk);
    bus.req_vld = 1'b0;
    waited = 0;
    while (!bus.start && waited < 10) begin
      @(negedge hclk);
      waited++;
    end
    checkOutput("midreset_start_seen", bus.start, 1'b1);
    repeat (3) @(negedge hclk);
    hrstn = 1'b0;
    #1;
    checkOutput("midreset_start", bus.start, 1'b0);
    checkOutput("midreset_cfg0", bus.cfg0, 32'h0);
    checkOutput("midreset_cfg1", bus.cfg1, 32'h0);
    checkOutput("midreset_cfg2", bus.cfg2, 32'h0);
    checkOutput("midreset_cfg3", bus.cfg3, 32'h0);
    checkOutput("midreset_busy", bus.busy, 1'b0);
    checkOutput("midreset_req_done", bus.req_done, 1'b0);
    @(negedge hclk);
    hrstn = 1'b1;
    @(negedge hclk);
    checkOutput("midreset_req_rdy_after", bus.req_rdy, 1'b1);
    checkOutput("midreset_no_req_done", bus.req_done, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd2, 24'h000200, 24'h000080, 10'h020, 4, n_st, g_err, g_cfg1);
    checkOutput("post_reset_bursts", n_st, 1);

    for (int i = 0; i < 16; i++) begin
      sel = int'($urandom_range(0, 9));
      pa = 24'($urandom) & 24'hFFFFFC;
      if (sel < 3) pa[9:2] = 8'($urandom_range(240, 255));
      if (sel == 7) pa[0] = 1'b1;
      ln = 24'($urandom_range(1, 384)) << 2;
      if (sel == 8) ln = '0;
      if (sel == 9) ln[1:0] = 2'b10;
      applyStimulus(1'($urandom), 1'($urandom), 4'($urandom), pa, ln, 10'($urandom), 0,
                    n_st, g_err, g_cfg1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
